// File: rtl/dlmiles_bad_sync_pkg.sv
// Shared constants for the bad/good synchronizer demonstration block:
// output-select encodings, status-bit positions and the fixed pad direction.
package dlmiles_bad_sync_pkg;

    localparam logic [2:0] SEL_GOOD = 3'd0;
    localparam logic [2:0] SEL_BAD  = 3'd1;
    localparam logic [2:0] SEL_MIS  = 3'd2;
    localparam logic [2:0] SEL_BUS  = 3'd3;
    localparam logic [2:0] SEL_LIVE = 3'd4;

    localparam int UIO_BAD_Q     = 1;
    localparam int UIO_GOOD_Q    = 2;
    localparam int UIO_MISMATCH  = 3;
    localparam int UIO_GOOD_RISE = 4;
    localparam int UIO_BAD_RISE  = 5;

    // uio[0] is the clear input; every other pad is an output.
    localparam logic [7:0] UIO_OE_VAL = 8'hFE;

endpackage

// File: rtl/dlmiles_bad_synchronizer_sync_chain.sv
// Plain shift-register synchronizer: STAGES flops deep, WIDTH bits wide,
// asynchronously cleared. STAGES=1 deliberately gives a single-flop sampler.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/dlmiles_bad_synchronizer.sv
// Tiny Tapeout demo: samples an async pin through a single flop and through a
// proper multi-flop chain, counting edges and disagreements between the two.
module dlmiles_bad_synchronizer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import dlmiles_bad_sync_pkg::*;

    logic       async_a;
    logic [2:0] sel;
    logic [3:0] async_bus;
    logic       unused_uio;

    assign async_a    = ui_in[0];
    assign sel        = ui_in[3:1];
    assign async_bus  = ui_in[7:4];
    assign unused_uio = &{1'b0, uio_in[7:1]};

    logic       bad_q, good_q, bad_al, clr_s;
    logic       bad_d_reg, good_d_reg;
    logic       bad_rise, good_rise, mismatch;
    logic [3:0] bad_bus, good_bus;

    sync_chain #(.STAGES(1), .WIDTH(1)) u_bad (
        .clk(clk), .rst_n(rst_n), .d(async_a), .q(bad_q)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_good (
        .clk(clk), .rst_n(rst_n), .d(async_a), .q(good_q)
    );
    // Delay the single-flop sample so it lines up with the good path in time.
    sync_chain #(.STAGES(SYNC_STAGES-1), .WIDTH(1)) u_align (
        .clk(clk), .rst_n(rst_n), .d(bad_q), .q(bad_al)
    );
    sync_chain #(.STAGES(2), .WIDTH(1)) u_clr (
        .clk(clk), .rst_n(rst_n), .d(uio_in[0]), .q(clr_s)
    );
    sync_chain #(.STAGES(1), .WIDTH(4)) u_bad_bus (
        .clk(clk), .rst_n(rst_n), .d(async_bus), .q(bad_bus)
    );

    // Each bus bit is synchronized independently, so the bus can tear.
    for (genvar gi = 0; gi < 4; gi++) begin : g_good_bus
        sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_bit (
            .clk(clk), .rst_n(rst_n), .d(async_bus[gi]), .q(good_bus[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_d_reg  <= 1'b0;
            good_d_reg <= 1'b0;
        end else begin
            bad_d_reg  <= bad_q;
            good_d_reg <= good_q;
        end
    end

    assign bad_rise  = bad_q & ~bad_d_reg;
    assign good_rise = good_q & ~good_d_reg;
    assign mismatch  = bad_al ^ good_q;

    logic [CNT_W-1:0] good_cnt_reg, bad_cnt_reg, mis_cnt_reg;

    // Clear wins over increment and ignores ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            mis_cnt_reg  <= '0;
        end else if (clr_s) begin
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            mis_cnt_reg  <= '0;
        end else if (ena) begin
            if (good_rise) good_cnt_reg <= good_cnt_reg + 1'b1;
            if (bad_rise)  bad_cnt_reg  <= bad_cnt_reg + 1'b1;
            if (mismatch)  mis_cnt_reg  <= mis_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        uo_out = 8'h00;
        case (sel)
            SEL_GOOD: uo_out = good_cnt_reg;
            SEL_BAD:  uo_out = bad_cnt_reg;
            SEL_MIS:  uo_out = mis_cnt_reg;
            SEL_BUS:  uo_out = {bad_bus, good_bus};
            SEL_LIVE: uo_out = {4'b0000, mismatch, bad_al, good_q, bad_q};
            default:  uo_out = 8'h00;
        endcase
    end

    always_comb begin
        uio_out                = 8'h00;
        uio_out[UIO_BAD_Q]     = bad_q;
        uio_out[UIO_GOOD_Q]    = good_q;
        uio_out[UIO_MISMATCH]  = mismatch;
        uio_out[UIO_GOOD_RISE] = good_rise;
        uio_out[UIO_BAD_RISE]  = bad_rise;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_dlmiles_bad_synchronizer.sv
// Directed bench for dlmiles_bad_synchronizer: inputs change on the falling
// edge, outputs are checked on the falling edge against hand-computed values.
module tb_dlmiles_bad_synchronizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run = 0;
    int tests_failed = 0;

    logic       a_v;
    logic [2:0] sel_v;
    logic [3:0] bus_v;

    dlmiles_bad_synchronizer #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive();
        ui_in = {bus_v, sel_v, a_v};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            a_v = 1'b1; drive(); cycles(3);
            a_v = 1'b0; drive(); cycles(3);
        end
    endtask

    task automatic clear_counters();
        uio_in = 8'h01; cycles(1);
        uio_in = 8'h00; cycles(3);
    endtask

    task automatic set_sel(input logic [2:0] s);
        sel_v = s; drive(); #1;
    endtask

    initial begin
        ena = 1'b1; uio_in = 8'h00; ui_in = 8'hFF;
        a_v = 1'b0; sel_v = 3'd0; bus_v = 4'h0;
        rst_n = 1'b0;

        // Reset with all inputs high
        cycles(5);
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'hFE);
        drive(); rst_n = 1'b1;
        cycles(3);
        check("post-reset uo_out", uo_out, 8'h00);

        // Latency of bad vs good path, sel=4 live view
        sel_v = 3'd4; drive(); cycles(2);
        a_v = 1'b1; drive(); cycles(1);
        check("edge1 live", uo_out, 8'h01);
        check("edge1 uio_out", uio_out, 8'h22);
        cycles(1);
        check("edge2 live", uo_out, 8'h07);
        check("edge2 uio_out", uio_out, 8'h16);
        cycles(1);
        check("edge3 live", uo_out, 8'h07);
        check("edge3 uio_out", uio_out, 8'h06);
        a_v = 1'b0; drive(); cycles(4);
        check("fall live", uo_out, 8'h00);
        set_sel(3'd0); check("latency good_cnt", uo_out, 8'h01);
        set_sel(3'd1); check("latency bad_cnt", uo_out, 8'h01);
        clear_counters();
        check("cleared bad_cnt", uo_out, 8'h00);

        // Ten pulses
        pulse(10);
        set_sel(3'd0); check("10 pulses good_cnt", uo_out, 8'h0A);
        set_sel(3'd1); check("10 pulses bad_cnt", uo_out, 8'h0A);
        set_sel(3'd2); check("10 pulses mis_cnt", uo_out, 8'h00);

        // Wrap and hold
        clear_counters();
        pulse(255);
        set_sel(3'd0); check("255 pulses good_cnt", uo_out, 8'hFF);
        pulse(1);
        check("wrap good_cnt", uo_out, 8'h00);
        set_sel(3'd1); check("wrap bad_cnt", uo_out, 8'h00);
        ena = 1'b0;
        pulse(5);
        set_sel(3'd0); check("ena low good_cnt", uo_out, 8'h00);
        set_sel(3'd1); check("ena low bad_cnt", uo_out, 8'h00);
        ena = 1'b1;
        pulse(1);
        set_sel(3'd0); check("ena high good_cnt", uo_out, 8'h01);
        set_sel(3'd1); check("ena high bad_cnt", uo_out, 8'h01);

        // Clear timing and clear priority
        clear_counters();
        pulse(7);
        set_sel(3'd0); check("pre-clear good_cnt", uo_out, 8'h07);
        uio_in = 8'h01; cycles(1);
        uio_in = 8'h00; cycles(1);
        check("clear edge2 good_cnt", uo_out, 8'h07);
        cycles(1);
        check("clear edge3 good_cnt", uo_out, 8'h00);
        uio_in = 8'h01;
        pulse(3);
        check("clear held good_cnt", uo_out, 8'h00);
        set_sel(3'd1); check("clear held bad_cnt", uo_out, 8'h00);
        uio_in = 8'hFE; cycles(3);
        pulse(1);
        check("unused uio bits bad_cnt", uo_out, 8'h01);
        uio_in = 8'h00;

        // Bus sampling
        set_sel(3'd3); check("bus idle", uo_out, 8'h00);
        bus_v = 4'hA; drive(); cycles(1);
        check("bus edge1 A", uo_out, 8'hA0);
        cycles(1);
        check("bus edge2 A", uo_out, 8'hAA);
        bus_v = 4'h5; drive(); cycles(1);
        check("bus edge1 5", uo_out, 8'h5A);
        cycles(1);
        check("bus edge2 5", uo_out, 8'h55);
        set_sel(3'd5); check("sel5", uo_out, 8'h00);
        set_sel(3'd7); check("sel7", uo_out, 8'h00);
        bus_v = 4'h0; drive();

        // Reset in the middle of activity
        clear_counters();
        pulse(2);
        set_sel(3'd0); check("pre-reset good_cnt", uo_out, 8'h02);
        a_v = 1'b1; drive(); cycles(1);
        check("pre-reset uio_out", uio_out, 8'h22);
        rst_n = 1'b0; #1;
        check("mid reset good_cnt", uo_out, 8'h00);
        check("mid reset uio_out", uio_out, 8'h00);
        a_v = 1'b0; drive();
        cycles(2); rst_n = 1'b1; cycles(4);
        set_sel(3'd1); check("after reset bad_cnt", uo_out, 8'h00);
        set_sel(3'd4); check("after reset live", uo_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
